// File: rtl/tdm_mux_8_to_1.sv
// Time-division multiplexer: accepts one 8-bit frame per handshake and serializes it
// onto a single bit line, tagging each bit with its 3-bit channel select.
module tdm_mux_8_to_1 #(
  parameter int unsigned ORDER = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dout,
  output logic [2:0] sel,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] frames_sent
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned CW = 8;
  localparam logic [PW-1:0] LAST_POS = PW'(7);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] frames_q, frames_d;

  // Output view of the registered frame position.
  assign sel         = (ORDER == 0) ? pos_q : LAST_POS - pos_q;
  assign dout        = shadow_q[sel];
  assign dout_valid  = (state_q == SEND);
  assign frame_start = dout_valid && (pos_q == '0);
  assign frame_end   = dout_valid && (pos_q == LAST_POS);
  assign frames_sent = frames_q;

  // Next-state logic; the last beat doubles as the reload window for the next frame.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    shadow_d = shadow_q;
    frames_d = frames_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          shadow_d = din;
          pos_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        in_ready = rst_n && (pos_q == LAST_POS) && dout_ready;
        if (dout_ready) begin
          if (pos_q != LAST_POS) begin
            pos_d = pos_q + PW'(1);
          end else begin
            frames_d = frames_q + CW'(1);
            pos_d    = '0;
            if (in_valid) begin
              shadow_d = din;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      shadow_q <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      shadow_q <= shadow_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_tdm_mux_8_to_1.sv
// Bench for tdm_mux_8_to_1: both channel orders side by side, checked against a
// beat-queue model every cycle plus directed literal expectations.
module tb_tdm_mux_8_to_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       in_valid;
  logic       dout_ready;

  logic       in_ready0, dout0, dout_valid0, fs0, fe0;
  logic [2:0] sel0;
  logic [7:0] frames0;
  logic       in_ready1, dout1, dout_valid1, fs1, fe1;
  logic [2:0] sel1;
  logic [7:0] frames1;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  always #5 clk = ~clk;

  tdm_mux_8_to_1 #(.ORDER(0)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready0),
    .dout(dout0), .sel(sel0), .dout_valid(dout_valid0), .dout_ready(dout_ready),
    .frame_start(fs0), .frame_end(fe0), .frames_sent(frames0)
  );

  tdm_mux_8_to_1 #(.ORDER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready1),
    .dout(dout1), .sel(sel1), .dout_valid(dout_valid1), .dout_ready(dout_ready),
    .frame_start(fs1), .frame_end(fe1), .frames_sent(frames1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is eight queued beats; the link pops one per ready cycle.
  typedef struct {
    logic [7:0] data;
    int         k;
  } beat_t;

  beat_t      q[$];
  logic [7:0] m_cnt = 8'd0;

  always @(negedge clk) begin
    if (armed) begin
      logic exp_ready;
      logic acc;
      exp_ready = rst_n && ((q.size() == 0) || ((q.size() == 1) && dout_ready));
      chk("m_in_ready0", 32'(in_ready0), 32'(exp_ready));
      chk("m_in_ready1", 32'(in_ready1), 32'(exp_ready));
      chk("m_valid0", 32'(dout_valid0), 32'(q.size() != 0));
      chk("m_valid1", 32'(dout_valid1), 32'(q.size() != 0));
      chk("m_frames0", 32'(frames0), 32'(m_cnt));
      chk("m_frames1", 32'(frames1), 32'(m_cnt));
      if (q.size() != 0) begin
        chk("m_sel0", 32'(sel0), 32'(q[0].k));
        chk("m_sel1", 32'(sel1), 32'(7 - q[0].k));
        chk("m_dout0", 32'(dout0), 32'(q[0].data[q[0].k]));
        chk("m_dout1", 32'(dout1), 32'(q[0].data[7 - q[0].k]));
        chk("m_fs0", 32'(fs0), 32'(q[0].k == 0));
        chk("m_fe0", 32'(fe0), 32'(q[0].k == 7));
        chk("m_fs1", 32'(fs1), 32'(q[0].k == 0));
        chk("m_fe1", 32'(fe1), 32'(q[0].k == 7));
      end else begin
        chk("m_fs_idle", 32'({fs0, fs1}), 32'd0);
        chk("m_fe_idle", 32'({fe0, fe1}), 32'd0);
      end
      // Advance using the inputs that the coming rising edge will sample.
      if (!rst_n) begin
        q.delete();
        m_cnt = 8'd0;
      end else begin
        acc = in_valid && exp_ready;
        if ((q.size() != 0) && dout_ready) begin
          if (q[0].k == 7) m_cnt = m_cnt + 8'd1;
          void'(q.pop_front());
        end
        if (acc) for (int k = 0; k < 8; k++) q.push_back('{din, k});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] c3c;
    int         p;
    a5  = 8'hA5;
    c3c = 8'h3C;
    rst_n      = 1'b0;
    din        = 8'h00;
    in_valid   = 1'b0;
    dout_ready = 1'b1;

    // Reset state, with in_valid offered while reset is held.
    tick;
    armed    = 1'b1;
    in_valid = 1'b1;
    din      = 8'hFF;
    #1;
    chk("rst_in_ready", 32'({in_ready0, in_ready1}), 32'd0);
    tick;
    chk("rst_valid", 32'({dout_valid0, dout_valid1}), 32'd0);
    chk("rst_dout", 32'({dout0, dout1}), 32'd0);
    chk("rst_sel0", 32'(sel0), 32'd0);
    chk("rst_sel1", 32'(sel1), 32'd7);
    chk("rst_marks", 32'({fs0, fe0, fs1, fe1}), 32'd0);
    chk("rst_frames", 32'(frames0), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'({in_ready0, in_ready1}), 32'h3);

    // Reset mid-frame at pos 5 aborts the frame with no count.
    din      = 8'h5A;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("abort_sel_at5", 32'(sel0), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'({in_ready0, in_ready1}), 32'd0);
    tick;
    chk("abort_valid", 32'({dout_valid0, dout_valid1}), 32'd0);
    chk("abort_frames", 32'(frames0), 32'd0);
    chk("abort_in_ready_rst", 32'(in_ready0), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready_rel", 32'(in_ready0), 32'd1);

    // 8'hA5, ORDER=0 view.
    din      = 8'hA5;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    din      = 8'h00;
    for (int b = 0; b < 8; b++) begin
      chk("a5_dout", 32'(dout0), 32'(a5[b]));
      chk("a5_sel", 32'(sel0), 32'(b));
      if (b == 0) chk("a5_start", 32'({fs0, fe0}), 32'h2);
      if (b == 7) chk("a5_end", 32'({fs0, fe0}), 32'h1);
      tick;
    end
    chk("a5_idle", 32'(dout_valid0), 32'd0);
    chk("a5_frames", 32'(frames0), 32'd1);

    // 8'h01, ORDER=1 view: only the final beat (channel 0) is high.
    din      = 8'h01;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("o1_sel", 32'(sel1), 32'(7 - b));
      chk("o1_dout", 32'(dout1), 32'(b == 7));
      tick;
    end
    chk("o1_frames", 32'(frames1), 32'd2);

    // Back-to-back FF then 00 with continuous in_valid.
    din      = 8'hFF;
    in_valid = 1'b1;
    tick;
    din = 8'h00;
    for (int b = 0; b < 16; b++) begin
      if (b == 15) in_valid = 1'b0;
      #1;
      chk("b2b_valid", 32'(dout_valid0), 32'd1);
      chk("b2b_in_ready", 32'(in_ready0), 32'((b == 7) || (b == 15)));
      chk("b2b_dout", 32'(dout0), 32'(b < 8));
      tick;
    end
    chk("b2b_idle", 32'(dout_valid0), 32'd0);
    chk("b2b_frames", 32'(frames0), 32'd4);

    // 8'h3C with a 3-cycle stall at pos 4; din churns throughout.
    din      = 8'h3C;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      dout_ready = !((c >= 4) && (c < 7));
      din        = 8'($urandom);
      p          = (c < 4) ? c : ((c < 7) ? 4 : c - 3);
      chk("stall_valid", 32'(dout_valid0), 32'd1);
      chk("stall_sel", 32'(sel0), 32'(p));
      chk("stall_dout", 32'(dout0), 32'(c3c[p]));
      tick;
    end
    chk("stall_idle", 32'(dout_valid0), 32'd0);
    chk("stall_frames", 32'(frames0), 32'd5);

    // 256 back-to-back frames from a fresh count wrap frames_sent to 0.
    rst_n = 1'b0;
    tick;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    din      = 8'($urandom);
    tick;
    for (int j = 0; j < 2048; j++) begin
      din = 8'($urandom);
      if (j == 2040) in_valid = 1'b0;
      if (j == 2047) chk("wrap_pre", 32'(frames0), 32'd255);
      tick;
    end
    chk("wrap_frames0", 32'(frames0), 32'd0);
    chk("wrap_frames1", 32'(frames1), 32'd0);
    chk("wrap_idle", 32'(dout_valid0), 32'd0);

    tick;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
